// File: rtl/seq_bus_datapath_pkg.sv
// Shared definitions for the single-bus datapath.
//   - opcode encodings (5-bit op field)
//   - micro-step state enum
//   - is_muldiv(): ops that write LO/HI instead of a GPR
package seq_bus_datapath_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SHL  = 5'd5;
  localparam logic [4:0] OP_SHR  = 5'd6;
  localparam logic [4:0] OP_SHRA = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_NEG  = 5'd10;
  localparam logic [4:0] OP_NOT  = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd12;
  localparam logic [4:0] OP_DIV  = 5'd13;
  localparam logic [4:0] OP_MFHI = 5'd14;
  localparam logic [4:0] OP_MFLO = 5'd15;

  typedef enum logic [2:0] {IDLE, LDY, EXE, WLO, WHI} state_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/seq_dp_alu.sv
// Combinational ALU for the single-bus datapath.
//   y, b   : operands (Y register, bus)
//   op     : opcode
//   hi, lo : HI/LO contents for MFHI/MFLO
//   z      : 2*DATA_W result (Zhi:Zlo)
//   div0   : DIV with zero divisor
module seq_dp_alu
  import seq_bus_datapath_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   y,
  input  logic [DATA_W-1:0]   b,
  input  logic [4:0]          op,
  input  logic [DATA_W-1:0]   hi,
  input  logic [DATA_W-1:0]   lo,
  output logic [2*DATA_W-1:0] z,
  output logic                div0
);
  localparam int SW = $clog2(DATA_W);

  logic [SW-1:0]       sh;
  logic [SW:0]         sh_inv;
  logic [DATA_W-1:0]   zlo, quo, rem, b_nz;
  logic [2*DATA_W-1:0] prod;

  assign sh     = b[SW-1:0];
  // complementary amount for rotates; sh=0 gives DATA_W, which shifts to 0
  assign sh_inv = (SW+1)'(DATA_W) - {1'b0, sh};

  assign prod = $signed({{DATA_W{y[DATA_W-1]}}, y}) * $signed({{DATA_W{b[DATA_W-1]}}, b});

  // divider never sees zero; the div0 path overrides its result
  assign div0 = (op == OP_DIV) && (b == '0);
  assign b_nz = (b == '0) ? DATA_W'(1) : b;
  assign quo  = $signed(y) / $signed(b_nz);
  assign rem  = $signed(y) % $signed(b_nz);

  always_comb begin
    zlo = '0;
    case (op)
      OP_ADD:  zlo = y + b;
      OP_SUB:  zlo = y - b;
      OP_AND:  zlo = y & b;
      OP_OR:   zlo = y | b;
      OP_XOR:  zlo = y ^ b;
      OP_SHL:  zlo = y << sh;
      OP_SHR:  zlo = y >> sh;
      OP_SHRA: zlo = $signed(y) >>> sh;
      OP_ROL:  zlo = (y << sh) | (y >> sh_inv);
      OP_ROR:  zlo = (y >> sh) | (y << sh_inv);
      OP_NEG:  zlo = -y;
      OP_NOT:  zlo = ~y;
      OP_MFHI: zlo = hi;
      OP_MFLO: zlo = lo;
      default: zlo = '0;
    endcase

    z = {{DATA_W{zlo[DATA_W-1]}}, zlo};
    if (op == OP_MUL)      z = prod;
    else if (op == OP_DIV) z = div0 ? {y, {DATA_W{1'b1}}} : {rem, quo};
  end

endmodule

// File: rtl/seq_bus_datapath.sv
// Single-bus CPU datapath with internal micro-step sequencer.
//   clk, clr      : clock, synchronous active-low reset
//   start, op,
//   ra/rb/rc,
//   imm_en, imm   : operation request, accepted only when idle
//   busy, done    : in-flight flag, one-cycle completion pulse
//   err           : divide-by-zero on the last operation
//   hi, lo        : HI/LO registers
//   dbg_sel/data  : combinational GPR read port
// Steps: LDY (Y<=R[rb]), EXE (Z<=ALU(Y,bus)), WLO (R[ra] or LO <= Zlo),
// WHI (HI <= Zhi, MUL/DIV only).
module seq_bus_datapath
  import seq_bus_datapath_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int NREGS   = 16,
  parameter  int R0_ZERO = 1,
  localparam int RW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [4:0]        op,
  input  logic [RW-1:0]     ra,
  input  logic [RW-1:0]     rb,
  input  logic [RW-1:0]     rc,
  input  logic              imm_en,
  input  logic [DATA_W-1:0] imm,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  input  logic [RW-1:0]     dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);
  typedef struct packed {
    logic [4:0]        op;
    logic [RW-1:0]     ra;
    logic [RW-1:0]     rb;
    logic [RW-1:0]     rc;
    logic              imm_en;
    logic [DATA_W-1:0] imm;
  } req_t;

  req_t                         req;
  state_t                       state;
  logic [NREGS-1:0][DATA_W-1:0] gpr;
  logic [DATA_W-1:0]            y, bus;
  logic [2*DATA_W-1:0]          z, alu_z;
  logic                         alu_div0;
  logic                         wr_en;

  // R0 is never written when R0_ZERO, so it stays at its reset value of 0
  // and reads need no masking.
  assign wr_en    = !((R0_ZERO != 0) && (req.ra == '0));
  assign dbg_data = gpr[dbg_sel];

  always_comb begin
    bus = '0;
    case (state)
      LDY:     bus = gpr[req.rb];
      EXE:     bus = req.imm_en ? req.imm : gpr[req.rc];
      WLO:     bus = z[DATA_W-1:0];
      WHI:     bus = z[2*DATA_W-1:DATA_W];
      default: bus = '0;
    endcase
  end

  seq_dp_alu #(.DATA_W(DATA_W)) u_alu (
    .y    (y),
    .b    (bus),
    .op   (req.op),
    .hi   (hi),
    .lo   (lo),
    .z    (alu_z),
    .div0 (alu_div0)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= IDLE;
      req   <= '0;
      gpr   <= '0;
      y     <= '0;
      z     <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          req   <= '{op: op, ra: ra, rb: rb, rc: rc, imm_en: imm_en, imm: imm};
          err   <= 1'b0;
          busy  <= 1'b1;
          state <= LDY;
        end
        LDY: begin
          y     <= bus;
          state <= EXE;
        end
        EXE: begin
          z     <= alu_z;
          err   <= alu_div0;
          state <= WLO;
        end
        WLO: if (is_muldiv(req.op)) begin
          lo    <= bus;
          state <= WHI;
        end else begin
          if (wr_en) gpr[req.ra] <= bus;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        WHI: begin
          hi    <= bus;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
